multiply_iter: RTL
==================

# multiply_iter

Parametrised multi-cycle multiplier replacing the single-cycle combinational multiplier in the EXE stage of the pipeline CPU. It resolves one multiplier bit per cycle with a shift-add datapath, trading latency for a short critical path. A begin/end handshake with busy and cancel lets the pipeline stall on it and flush it. Signed (MULT/MADD-style) operation is supported when enabled at build time.

## Interface
- WIDTH, 32, operand width in bits; product is 2*WIDTH; legal range 4..64.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mult_begin  in  1  start request; sampled only when idle.
- mult_op1  in  WIDTH  multiplicand; sampled with an accepted begin.
- mult_op2  in  WIDTH  multiplier; sampled with an accepted begin.
- mult_signed  in  1  1 = two's-complement operands; sampled with an accepted begin.
- mult_cancel  in  1  aborts an in-flight operation.
- product  out  2*WIDTH  registered result; holds until the next completion.
- mult_busy  out  1  operation in flight.
- mult_end  out  1  one-cycle pulse; product is valid in this cycle.

## Operation
- States: IDLE, CALC. Reset forces IDLE, product=0, mult_busy=0, mult_end=0, and clears the counter and internal registers.
- IDLE with mult_begin=1:
  - Latch |op1| and |op2|. Signed mode takes the absolute value of negative operands; unsigned mode uses the raw values.
  - Latch the result sign as sign(op1) XOR sign(op2), or 0 when unsigned.
  - Clear the 2*WIDTH accumulator and the counter, then enter CALC.
- CALC, each cycle:
  - If the current multiplier LSB is 1, add the multiplicand into the upper half of the accumulator, keeping WIDTH+1 bits for the carry.
  - Shift the accumulator and multiplier right by 1 and increment the counter.
- Last iteration (counter = WIDTH-1):
  - Write product with the final value, two's-complement negated when the latched sign is 1.
  - Assert mult_end for exactly one cycle and return to IDLE.
- Arithmetic: the result is exact modulo 2^(2*WIDTH). The most negative value is legal: its absolute value fits unsigned in WIDTH bits.
- mult_begin in CALC is ignored; the operands are not latched.
- mult_cancel in CALC: IDLE at the next edge, no mult_end, product unchanged.
- mult_cancel in IDLE has no effect. Begin and cancel together in IDLE: begin is accepted.
- mult_cancel on the final CALC cycle: the cancel wins, with no product write and no mult_end.
- Async reset mid-operation aborts immediately; the result is discarded.

## Timing
- Accept edge E0 (IDLE, begin=1): mult_busy=1 from E0 until edge E_WIDTH.
- Iterations run on edges E1..E_WIDTH.
- mult_end=1 and the new product are visible in the cycle after E_WIDTH, i.e. latency WIDTH+1 cycles from the begin cycle to the end cycle (33 for WIDTH=32).
- mult_busy=0 during the mult_end cycle. A begin in that same cycle is accepted, giving back-to-back throughput of one result per WIDTH+1 cycles.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Configuration
- MULT_SIGNED_EN defined: mult_signed is honoured, and the abs/negate logic is compiled in.
- MULT_SIGNED_EN undefined: mult_signed is ignored, all operations are unsigned, and no abs/negate logic is built. The port remains present so the integration is identical in both builds.

## Structure
- Shared package/header mult_defs: the state encodings (MULT_IDLE, MULT_CALC) and the counter width as a function of WIDTH, clog2(WIDTH).
- One sub-module, mult_neg: parametrised conditional two's-complement negate. It is instanced for op1 abs, op2 abs and the final product fix-up, and only under MULT_SIGNED_EN.

## Test plan
- Unsigned, WIDTH=32: 0xFFFFFFFF * 0xFFFFFFFF -> product=0xFFFFFFFE00000001, with mult_end exactly 33 cycles after the begin cycle and busy high for 32 cycles.
- Signed (MULT_SIGNED_EN): -3 * 5 -> 0xFFFFFFFFFFFFFFF1; 0x80000000 * 0x80000000 -> 0x4000000000000000.
- Same -3 * 5 with MULT_SIGNED_EN undefined and mult_signed=1 -> 0x00000004FFFFFFF1.
- Cancel on the 10th CALC cycle -> busy drops at the next edge, no mult_end, product retains the previous result. A begin pulse during busy is ignored.
- Back-to-back: begin asserted in the mult_end cycle with 7 * 6 -> accepted, and 42 is produced 33 cycles later.
- rst asserted mid-CALC -> product=0, busy=0 and end=0 immediately. A subsequent 2 * 3 -> 6.

Source files
------------

// File: rtl/mult_defs_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding and
// the iteration counter width derived from the operand width.
package mult_defs_pkg;

  typedef enum logic {
    MULT_IDLE = 1'b0,
    MULT_CALC = 1'b1
  } mult_state_t;

  // Counter must hold 0..WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_neg.sv
// Conditional two's-complement negate, used for operand abs and result sign
// fix-up. Only built when MULT_SIGNED_EN is defined.
`ifdef MULT_SIGNED_EN
module mult_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule
`endif

// File: rtl/multiply_iter.sv
// Multi-cycle shift-add multiplier, one multiplier bit per cycle, with a
// begin/end/busy/cancel handshake. Signed mode is built only with MULT_SIGNED_EN.
module multiply_iter
  import mult_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mult_begin,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  input  logic               mult_signed,
  input  logic               mult_cancel,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_busy,
  output logic               mult_end
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t     state, state_next;
  logic [WIDTH-1:0] mcand_q, mcand_d, mpr_q, mpr_d;
  logic [WIDTH-1:0] op1_eff, op2_eff;
  logic [PW-1:0]    acc_q, acc_d, acc_shift, result, product_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic             busy_d, end_d;

  // Add into the upper half with one carry bit, then shift the whole accumulator.
  assign sum       = {1'b0, acc_q[PW-1:WIDTH]} + (mpr_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_shift = {sum, acc_q[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic sign_q;
  logic sign_in;

  assign sign_in = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);

  mult_neg #(.W(WIDTH)) u_abs_op1 (
    .neg  (mult_signed & mult_op1[WIDTH-1]),
    .din  (mult_op1),
    .dout (op1_eff)
  );

  mult_neg #(.W(WIDTH)) u_abs_op2 (
    .neg  (mult_signed & mult_op2[WIDTH-1]),
    .din  (mult_op2),
    .dout (op2_eff)
  );

  mult_neg #(.W(PW)) u_fix_result (
    .neg  (sign_q),
    .din  (acc_shift),
    .dout (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sign_q <= 1'b0;
    else if (state == MULT_IDLE && mult_begin)
      sign_q <= sign_in;
  end
`else
  logic unused_signed;

  assign unused_signed = mult_signed;
  assign op1_eff       = mult_op1;
  assign op2_eff       = mult_op2;
  assign result        = acc_shift;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= MULT_IDLE;
    else
      state <= state_next;
  end

  // Cancel has priority over the final iteration, so a late cancel never writes product.
  always_comb begin
    state_next = state;
    mcand_d    = mcand_q;
    mpr_d      = mpr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    product_d  = product;
    busy_d     = mult_busy;
    end_d      = 1'b0;
    case (state)
      MULT_IDLE: begin
        busy_d = 1'b0;
        if (mult_begin) begin
          mcand_d    = op1_eff;
          mpr_d      = op2_eff;
          acc_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_next = MULT_CALC;
        end
      end
      MULT_CALC: begin
        if (mult_cancel) begin
          busy_d     = 1'b0;
          state_next = MULT_IDLE;
        end else begin
          acc_d = acc_shift;
          mpr_d = mpr_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            product_d  = result;
            end_d      = 1'b1;
            busy_d     = 1'b0;
            state_next = MULT_IDLE;
          end
        end
      end
      default: state_next = MULT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      mpr_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product   <= '0;
      mult_busy <= 1'b0;
      mult_end  <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mpr_q     <= mpr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product   <= product_d;
      mult_busy <= busy_d;
      mult_end  <= end_d;
    end
  end

endmodule
